// File: rtl/trace_mgmt_stream_arbiter.sv
// trace_mgmt_stream_arbiter: packet-aware round-robin arbiter for the mgmt Avalon-ST path.
// Optional macro TRACE_ARB_DROP_COUNT_EN adds a saturating suppressed-packet counter port.
module trace_mgmt_stream_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int CHANNEL_W   = 2,
    parameter int MAX_CHANNEL = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        in_valid,
    output logic [NUM_REQ-1:0]        in_ready,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    input  logic [NUM_REQ-1:0]        in_sop,
    input  logic [NUM_REQ-1:0]        in_eop,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [CHANNEL_W-1:0]      out_channel,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      busy
`ifdef TRACE_ARB_DROP_COUNT_EN
    ,
    output logic [15:0]               drop_count
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] grant_nxt;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] last_nxt;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             g_valid;
    logic             g_sop;
    logic             g_eop;
    logic [DATA_W-1:0] g_data;
    logic             out_ok;
    logic             accept;
    logic             suppress;

    assign g_valid  = in_valid[grant_idx];
    assign g_sop    = in_sop[grant_idx];
    assign g_eop    = in_eop[grant_idx];
    assign g_data   = in_data[int'(grant_idx)*DATA_W +: DATA_W];
    assign out_ok   = ~out_valid | out_ready;
    assign accept   = (state == LOCKED) & g_valid & out_ok;
    assign suppress = (int'(grant_idx) > MAX_CHANNEL);
    assign busy     = (state == LOCKED);

    // Round-robin search for a packet start, beginning after the last winner
    always_comb begin
        int idx;
        idx     = 0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!hit && in_valid[idx] && in_sop[idx]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(idx);
            end
        end
    end

    // Only the locked source sees ready, and only when the output slot can take a beat
    always_comb begin
        in_ready = '0;
        if (state == LOCKED) begin
            in_ready[grant_idx] = out_ok;
        end
    end

    // Next-state: lock on a found sop, release on an accepted eop
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_idx;
        last_nxt  = last_grant;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    grant_nxt = hit_idx;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && g_eop) begin
                    last_nxt  = grant_idx;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // FSM state, grant and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            grant_idx  <= grant_nxt;
            last_grant <= last_nxt;
        end
    end

    // Output register: load on accept, drop valid for drained sources, clear once taken
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
        end else if (accept) begin
            out_valid   <= ~suppress;
            out_data    <= g_data;
            out_channel <= CHANNEL_W'(grant_idx);
            out_sop     <= g_sop;
            out_eop     <= g_eop;
        end else if (out_ready && out_valid) begin
            out_valid   <= 1'b0;
        end
    end

`ifdef TRACE_ARB_DROP_COUNT_EN
    // Count packets drained without forwarding, saturating at all ones
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (accept && g_eop && suppress && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

    logic unused;
    assign unused = ^{g_sop, 1'b0};

endmodule

// File: tb/tb_trace_mgmt_stream_arbiter.sv
// tb_trace_mgmt_stream_arbiter: vector table, directed corner sequences and
// randomized packet traffic checked against a queue-based arbitration model.
module tb_trace_mgmt_stream_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int CW   = 2;
    localparam int MAXC = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] in_valid;
    logic [NREQ-1:0] in_ready;
    logic [NREQ*DW-1:0] in_data;
    logic [NREQ-1:0] in_sop;
    logic [NREQ-1:0] in_eop;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_channel;
    logic            out_sop;
    logic            out_eop;
    logic            busy;
`ifdef TRACE_ARB_DROP_COUNT_EN
    logic [15:0]     drop_count;
`endif

    trace_mgmt_stream_arbiter #(
        .NUM_REQ(NREQ), .DATA_W(DW), .CHANNEL_W(CW), .MAX_CHANNEL(MAXC)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_channel(out_channel), .out_sop(out_sop), .out_eop(out_eop),
        .busy(busy)
`ifdef TRACE_ARB_DROP_COUNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_busy;
        logic       e_ov;
        logic [1:0] e_ch;
    } vec_t;

    vec_t tbl[18];

    // ---------------- reference model state ----------------
    typedef struct packed {logic [7:0] d; logic s; logic e;} beat_t;
    typedef struct packed {logic [7:0] d; logic s; logic e; logic [1:0] ch;} obeat_t;

    beat_t  src_q[NREQ][$];
    obeat_t exp_q[$];
    int     glog[$];
    bit     exp_busy;
    int     exp_g;
    int     last_g;
    bit     first_beat;
    bit     prev_hold;
    logic [11:0] prev_out;
    int     drops;
    int     acc_cnt[NREQ];
    int     ov_seen;
    int     vprob = 100;
    int     rprob = 100;
    int     ordy_force = -1;
    logic [3:0]  obs_ready;
    logic [7:0]  obs_data;
    logic [17:0] obs_all;

    task automatic model_reset();
        exp_q.delete();
        glog.delete();
        exp_busy   = 1'b0;
        exp_g      = 0;
        last_g     = NREQ - 1;
        first_beat = 1'b0;
        prev_hold  = 1'b0;
        drops      = 0;
        ov_seen    = 0;
        for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
    endtask

    task automatic push_pkt(input int src, input int len, input logic [7:0] base, input bit midsop);
        for (int j = 0; j < len; j++) begin
            beat_t b;
            b.d = base + 8'(j);
            b.s = (j == 0) || (midsop && j != len - 1 && $urandom_range(3) == 0);
            b.e = (j == len - 1);
            src_q[src].push_back(b);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() != 0 && $urandom_range(99) < vprob) begin
                in_valid[i]         = 1'b1;
                in_data[i*DW +: DW] = src_q[i][0].d;
                in_sop[i]           = src_q[i][0].s;
                in_eop[i]           = src_q[i][0].e;
            end else begin
                in_valid[i]         = 1'b0;
                in_data[i*DW +: DW] = 8'($urandom);
                in_sop[i]           = 1'($urandom);
                in_eop[i]           = 1'($urandom);
            end
        end
        if (ordy_force >= 0) out_ready = (ordy_force != 0);
        else out_ready = ($urandom_range(99) < rprob);
    endtask

    task automatic monitor();
        bit         ov_m;
        logic [3:0] want;
        int         h;
        ov_m      = (exp_q.size() != 0);
        obs_ready = in_ready;
        obs_data  = out_data;
        obs_all   = {out_valid, busy, out_data, out_sop, out_eop, out_channel, in_ready};
        if (out_valid) ov_seen++;
        chk("busy", busy, exp_busy);
        chk("out_valid", out_valid, ov_m);
        if (prev_hold) chk("hold", {out_data, out_sop, out_eop, out_channel}, prev_out);
        if (out_valid && out_ready && ov_m) begin
            obeat_t e;
            e = exp_q.pop_front();
            chk("out_beat", {out_data, out_sop, out_eop, out_channel}, e);
        end
        prev_hold = out_valid & ~out_ready;
        prev_out  = {out_data, out_sop, out_eop, out_channel};
        if (!exp_busy) begin
            chk("idle_ready", in_ready, 0);
            h = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (last_g + k) % NREQ;
                if (h < 0 && in_valid[i] && in_sop[i]) h = i;
            end
            if (h >= 0) begin
                exp_g      = h;
                exp_busy   = 1'b1;
                first_beat = 1'b1;
            end
        end else begin
            want = (!ov_m || out_ready) ? (4'b1 << exp_g) : 4'b0;
            chk("lock_ready", in_ready, want);
            if (in_valid[exp_g] && want[exp_g]) begin
                beat_t b;
                b = src_q[exp_g].pop_front();
                acc_cnt[exp_g]++;
                if (first_beat) glog.push_back(exp_g);
                first_beat = 1'b0;
                if (exp_g <= MAXC) exp_q.push_back({b.d, b.s, b.e, 2'(exp_g)});
                if (b.e) begin
                    last_g   = exp_g;
                    exp_busy = 1'b0;
                    if (exp_g > MAXC) drops++;
                end
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        model_reset();
        drive();
    endtask

    function automatic bit pending();
        bit p;
        p = exp_busy || (exp_q.size() != 0);
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (pending() && n < maxc) begin
            run_cycle();
            n++;
        end
        chk("drain_in_budget", (n < maxc), 1);
    endtask

    task automatic chk_drops(input string name);
`ifdef TRACE_ARB_DROP_COUNT_EN
        chk(name, drop_count, drops);
`else
        chk(name, 32'(drops) >= 0, 1);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[8];
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

        tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0};
        tbl[6]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, 2'd1};
        tbl[8]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 1'b0, 2'd0};
        tbl[9]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, 2'd2};
        tbl[10] = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 1'b0, 2'd0};
        tbl[11] = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0};
        tbl[12] = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0, 2'd0};
        tbl[13] = '{1'b0, 4'h3, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0};
        tbl[14] = '{1'b0, 4'h3, 1'b1, 4'h2, 1'b1, 1'b0, 2'd0};
        tbl[15] = '{1'b0, 4'h3, 1'b1, 4'h0, 1'b0, 1'b1, 2'd1};
        tbl[16] = '{1'b0, 4'h3, 1'b1, 4'h1, 1'b1, 1'b0, 2'd0};
        tbl[17] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0};

        // Table phase: single-beat packets, fixed per-source data A0+i
        reset     = 1'b1;
        in_valid  = 4'hF;
        in_sop    = 4'hF;
        in_eop    = 4'hF;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < 18; r++) begin
            reset     = tbl[r].rst;
            in_valid  = tbl[r].vld;
            in_sop    = tbl[r].vld;
            in_eop    = tbl[r].vld;
            out_ready = tbl[r].ordy;
            @(negedge clk);
            chk($sformatf("t%0d_in_ready", r), in_ready, tbl[r].e_rdy);
            chk($sformatf("t%0d_busy", r), busy, tbl[r].e_busy);
            chk($sformatf("t%0d_out_valid", r), out_valid, tbl[r].e_ov);
            if (tbl[r].e_ov) begin
                logic [7:0] ed;
                ed = 8'hA0 + {6'b0, tbl[r].e_ch};
                chk($sformatf("t%0d_channel", r), out_channel, tbl[r].e_ch);
                chk($sformatf("t%0d_data", r), out_data, ed);
                chk($sformatf("t%0d_sop_eop", r), {out_sop, out_eop}, 2'b11);
            end
            @(posedge clk);
            #1;
        end
`ifdef TRACE_ARB_DROP_COUNT_EN
        chk("table_drop_count", drop_count, 1);
`endif

        // Fairness: every source streams 2-beat packets
        do_reset(2);
        vprob = 100; rprob = 100; ordy_force = -1;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NREQ; i++)
                push_pkt(i, 2, 8'(16 * i + 4 * p), 1'b0);
        drive();
        drain(200);
        chk("fair_pkts", glog.size(), 8);
        for (int k = 0; k < 8 && k < glog.size(); k++)
            chk($sformatf("fair_order%0d", k), glog[k], exp_order[k]);
        chk_drops("fair_drops");

        // Backpressure: output stalls 5 cycles with one beat buffered
        do_reset(1);
        ordy_force = 1;
        push_pkt(0, 4, 8'h40, 1'b0);
        drive();
        run_cycle();
        run_cycle();
        ordy_force = 0;
        run_cycle();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) ordy_force = 1;
            run_cycle();
            chk($sformatf("bp_data%0d", k), obs_data, 8'h41);
            chk($sformatf("bp_ready%0d", k), obs_ready, 4'h0);
        end
        drain(100);
        chk("bp_accepts", acc_cnt[0], 4);
        ordy_force = -1;

        // Suppression: source above MAX_CHANNEL is drained, never forwarded
        do_reset(1);
        push_pkt(3, 3, 8'h30, 1'b0);
        drive();
        drain(100);
        chk("sup_accepts", acc_cnt[3], 3);
        chk("sup_out_valid_seen", ov_seen, 0);
        chk_drops("sup_drops");

        // Reset mid-packet: beat 2 of 4 in flight
        do_reset(1);
        ordy_force = 1;
        push_pkt(0, 4, 8'h50, 1'b0);
        drive();
        for (int k = 0; k < 20 && acc_cnt[0] < 2; k++) run_cycle();
        chk("rm_two_accepted", acc_cnt[0], 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        push_pkt(1, 2, 8'h60, 1'b0);
        drive();
        run_cycle();
        chk("rm_outputs_zero", obs_all, 0);
        for (int k = 0; k < 10; k++) run_cycle();
        chk("rm_src1_accepts", acc_cnt[1], 2);
        chk("rm_orphan_held", acc_cnt[0], 0);
        chk("rm_first_grant", (glog.size() != 0) ? glog[0] : -1, 1);
        src_q[0].delete();
        drive();
        drain(100);
        ordy_force = -1;

        // Randomized traffic against the model
        do_reset(1);
        vprob = 70; rprob = 70;
        for (int n = 0; n < 40; n++)
            push_pkt(int'($urandom_range(NREQ - 1)), int'($urandom_range(4, 1)), 8'(n * 16), 1'b1);
        drive();
        drain(4000);
        chk_drops("rand_drops");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
